// File: rtl/lib_arb_requester.sv
// rtl/lib_arb_requester.sv - request FIFO feeding per-destination round-robin arbiters
module lib_arb_requester #(
  parameter int N            = 4,
  parameter int DEPTH        = 8,
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     i_data,
  input  logic [$clog2(N)-1:0] i_dest,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [0:N-1]         o_request,
  input  logic [0:N-1]         i_grant,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  output logic                 o_starve,
  output logic                 o_grant_err
);

  localparam int DW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DW-1:0]    mem_dest [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    wait_cnt;
  logic [SW-1:0]    wait_nxt;
  logic             push;
  logic             pop;

  assign o_ready = (count < FULL);
  assign push    = i_valid && o_ready;
  assign pop     = |(i_grant & o_request);

  // Head is only visible once registered: no fall-through from i_data.
  always_comb begin
    o_request = '0;
    if (count != '0) o_request[mem_dest[rd_ptr]] = 1'b1;
  end

  always_comb begin
    wait_nxt = wait_cnt;
    if (count == '0 || pop)   wait_nxt = '0;
    else if (wait_cnt != LIMIT) wait_nxt = wait_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= i_data;
      mem_dest[wr_ptr] <= i_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wait_cnt    <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_starve    <= 1'b0;
      o_grant_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop) o_data <= mem_data[rd_ptr];
      o_valid     <= pop;
      wait_cnt    <= wait_nxt;
      // Registered from the next count so it tracks wait_cnt without extra lag.
      o_starve    <= (wait_nxt == LIMIT);
      o_grant_err <= |(i_grant & ~o_request);
    end
  end

endmodule

// File: doc/lib_arb_requester.md
LIB_ARB_REQUESTER -- requirements
Module: lib_arb_requester

Interface
REQ-001 Parameter N, default 4, number of destinations, each served by its own round-robin arbiter; N SHALL be >= 2.
REQ-002 Parameter DEPTH, default 8, FIFO entries; DEPTH SHALL be a power of 2 and >= 2.
REQ-003 Parameter WIDTH, default 32, payload width in bits.
REQ-004 Parameter STARVE_LIMIT, default 16, head-wait cycles before starvation flag; STARVE_LIMIT SHALL be >= 1.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 i_data  input  WIDTH  payload to enqueue.
REQ-008 i_dest  input  $clog2(N)  destination index of i_data.
REQ-009 i_valid  input  1  enqueue request.
REQ-010 o_ready  output  1  FIFO can accept an entry this cycle.
REQ-011 o_request  output  [0:N-1]  one-hot request to arbiter at destination index of FIFO head; all-zero when FIFO is empty.
REQ-012 i_grant  input  [0:N-1]  grant bits; bit d comes from arbiter d and is combinational on o_request (same cycle).
REQ-013 o_data  output  WIDTH  payload of the granted entry.
REQ-014 o_valid  output  1  o_data valid, one-cycle pulse per granted entry.
REQ-015 o_starve  output  1  head has waited >= STARVE_LIMIT cycles.
REQ-016 o_grant_err  output  1  one-cycle pulse: grant received on a bit not currently requested.

Function
REQ-017 Storage SHALL be a circular FIFO with read pointer, write pointer (both $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0) and occupancy count 0..DEPTH.
REQ-018 o_ready SHALL equal (count < DEPTH); it does not account for a same-cycle pop (no full bypass).
REQ-019 Push: i_valid && o_ready at posedge writes {i_data, i_dest} at write pointer and advances it; i_valid with o_ready low is dropped and the source holds.
REQ-020 No fall-through: an entry pushed into an empty FIFO drives o_request from the next cycle onward.
REQ-021 o_request SHALL be combinational from count != 0 and head i_dest, exactly one bit set when non-empty.
REQ-022 Pop: a grant is accepted when |(i_grant & o_request); head is removed at that posedge and the read pointer advances.
REQ-023 On accepted grant, o_data SHALL be registered with head payload and o_valid asserted in the following cycle only (latency 1 from grant to o_valid).
REQ-024 o_data SHALL hold its last value when o_valid is low.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance; legal at any count 1..DEPTH-1; at count DEPTH only pop occurs.
REQ-026 Any set bit of i_grant & ~o_request SHALL raise o_grant_err for the following cycle; such bits are otherwise ignored; a valid grant bit in the same vector is still accepted.
REQ-027 Wait counter: cleared on reset, on accepted grant, and while FIFO empty; otherwise increments by 1 each cycle, saturating at STARVE_LIMIT.
REQ-028 o_starve SHALL be registered, equal to (wait counter == STARVE_LIMIT), and deassert the cycle after the head is granted.
REQ-029 Back-to-back grants SHALL pop one entry per cycle, giving o_valid on consecutive cycles.

Reset
REQ-030 While reset is high at posedge: pointers and count = 0, wait counter = 0, o_valid = 0, o_data = 0, o_starve = 0, o_grant_err = 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; o_request is all-zero and o_ready = 1 in the first cycle after reset.
REQ-032 Grants during or in the first cycle after reset SHALL cause no pop; any nonzero i_grant then pulses o_grant_err only after reset deasserts.

Verification
REQ-033 N=4: push data 0xA5, dest 2 into empty FIFO -> next cycle o_request=0010; grant 0010 that cycle -> o_valid=1, o_data=0xA5 one cycle later, o_request=0000.
REQ-034 DEPTH=8: push 8 entries, no grants -> o_ready=0 after 8th push; 9th i_valid dropped; grant all 8 back-to-back -> 8 consecutive o_valid pulses in push order, pointers wrap correctly.
REQ-035 Count=8 with push and valid grant same cycle -> only pop occurs, count=7, o_ready=1 next cycle.
REQ-036 Head dest 1, grant 1000 -> no pop, o_grant_err pulses once next cycle, o_request stays 0100.
REQ-037 STARVE_LIMIT=16: head never granted -> o_starve rises after 16 waiting cycles; grant head -> o_starve low next cycle.
REQ-038 Reset with 5 entries queued -> next cycle o_request=0000, o_ready=1, o_valid=0, o_starve=0.
